// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage ALU with ALUOp/funct decode, registered valid/ready
// handshake and an iterative shift-add multiplier.
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int MUL_EN  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         alu_op,
    input  logic [5:0]         funct,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [3:0]         func_code,
    output logic               zero,
    output logic               overflow,
    output logic               illegal
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [3:0] FC_ADD   = 4'd0;
    localparam logic [3:0] FC_SUB   = 4'd1;
    localparam logic [3:0] FC_AND   = 4'd2;
    localparam logic [3:0] FC_OR    = 4'd3;
    localparam logic [3:0] FC_NOR   = 4'd4;
    localparam logic [3:0] FC_SLT   = 4'd5;
    localparam logic [3:0] FC_PASSB = 4'd6;
    localparam logic [3:0] FC_ADDIU = 4'd7;
    localparam logic [3:0] FC_SLTU  = 4'd8;
    localparam logic [3:0] FC_XOR   = 4'd9;
    localparam logic [3:0] FC_SLL   = 4'd10;
    localparam logic [3:0] FC_SRL   = 4'd11;
    localparam logic [3:0] FC_SRA   = 4'd12;
    localparam logic [3:0] FC_MULT  = 4'd13;
    localparam logic [3:0] FC_ILL   = 4'd15;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        HOLD
    } state_t;

    state_t state, state_nxt;

    logic [3:0]       dec_fc;
    logic             dec_ovf_en;
    logic [WIDTH-1:0] sum, diff;
    logic [WIDTH-1:0] exec_res;
    logic             exec_ovf;

    logic [WIDTH-1:0] mcand, mplier, acc;
    logic [WIDTH-1:0] step_acc;
    logic [CNT_W-1:0] cnt;
    logic             mul_last;

    assign sum      = op_a + op_b;
    assign diff     = op_a - op_b;
    assign step_acc = acc + (mplier[0] ? mcand : '0);
    assign mul_last = (cnt == CNT_W'(1));

    // Decode ALUOp/funct into the function code; only funct add/sub may flag overflow
    always_comb begin
        dec_fc     = FC_ILL;
        dec_ovf_en = 1'b0;
        if (alu_op == 4'b0000) begin
            case (funct)
                6'h20:   begin dec_fc = FC_ADD; dec_ovf_en = 1'b1; end
                6'h22:   begin dec_fc = FC_SUB; dec_ovf_en = 1'b1; end
                6'h24:   dec_fc = FC_AND;
                6'h25:   dec_fc = FC_OR;
                6'h27:   dec_fc = FC_NOR;
                6'h2a:   dec_fc = FC_SLT;
                6'h2b:   dec_fc = FC_SLTU;
                6'h26:   dec_fc = FC_XOR;
                6'h00:   dec_fc = FC_SLL;
                6'h02:   dec_fc = FC_SRL;
                6'h03:   dec_fc = FC_SRA;
                6'h18:   dec_fc = (MUL_EN != 0) ? FC_MULT : FC_ILL;
                default: dec_fc = FC_ILL;
            endcase
        end else begin
            case (alu_op)
                4'b0001: dec_fc = FC_SUB;
                4'b0010: dec_fc = FC_ADD;
                4'b0011: dec_fc = FC_PASSB;
                4'b0100: dec_fc = FC_ADDIU;
                4'b0101: dec_fc = FC_SLT;
                4'b0110: dec_fc = FC_SLTU;
                4'b0111: dec_fc = FC_AND;
                4'b1000: dec_fc = FC_OR;
                4'b1001: dec_fc = FC_XOR;
                default: dec_fc = FC_ILL;
            endcase
        end
    end

    // Single-cycle datapath for every operation except mult
    always_comb begin
        exec_res = '0;
        exec_ovf = 1'b0;
        case (dec_fc)
            FC_ADD: begin
                exec_res = sum;
                exec_ovf = dec_ovf_en && (op_a[WIDTH-1] == op_b[WIDTH-1])
                           && (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            FC_SUB: begin
                exec_res = diff;
                exec_ovf = dec_ovf_en && (op_a[WIDTH-1] != op_b[WIDTH-1])
                           && (diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            FC_AND:   exec_res = op_a & op_b;
            FC_OR:    exec_res = op_a | op_b;
            FC_NOR:   exec_res = ~(op_a | op_b);
            FC_SLT:   exec_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            FC_PASSB: exec_res = op_b;
            FC_ADDIU: exec_res = sum;
            FC_SLTU:  exec_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
            FC_XOR:   exec_res = op_a ^ op_b;
            FC_SLL:   exec_res = op_b << shamt;
            FC_SRL:   exec_res = op_b >> shamt;
            FC_SRA:   exec_res = $signed(op_b) >>> shamt;
            default:  exec_res = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = (dec_fc == FC_MULT) ? MUL : HOLD;
            MUL:     if (mul_last) state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs follow the state directly
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == HOLD);
    end

    // Result registers and multiplier datapath; the final mult step writes its
    // sum straight into result so HOLD is entered WIDTH edges after acceptance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result    <= '0;
            func_code <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (dec_fc == FC_MULT) begin
                            mcand  <= op_a;
                            mplier <= op_b;
                            acc    <= '0;
                            cnt    <= CNT_W'(WIDTH);
                        end else begin
                            result    <= exec_res;
                            func_code <= dec_fc;
                            zero      <= (exec_res == '0);
                            overflow  <= exec_ovf;
                            illegal   <= (dec_fc == FC_ILL);
                        end
                    end
                end
                MUL: begin
                    acc    <= step_acc;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CNT_W'(1);
                    if (mul_last) begin
                        result    <= step_acc;
                        func_code <= FC_MULT;
                        zero      <= (step_acc == '0);
                        overflow  <= 1'b0;
                        illegal   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and randomized checks of alu_exec_unit against
// an arithmetic reference model.
module tb_alu_exec_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    alu_op;
    logic [5:0]    funct;
    logic [4:0]    shamt;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [3:0]    func_code;
    logic          zero;
    logic          overflow;
    logic          illegal;

    int unsigned total  = 0;
    int unsigned passed = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(
        .WIDTH   (W),
        .SHAMT_W (5),
        .MUL_EN  (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct     (funct),
        .shamt     (shamt),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .func_code (func_code),
        .zero      (zero),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Reference: decode to function code and expected result/overflow
    function automatic void model(input logic [3:0] aop, input logic [5:0] fn,
                                  input logic [4:0] sh, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] res,
                                  output logic [3:0] fc, output logic ovf);
        longint      true_val;
        logic [63:0] prod;
        res = 32'd0;
        fc  = 4'd15;
        ovf = 1'b0;
        if (aop == 4'd0) begin
            case (fn)
                6'h20: begin
                    fc = 0; res = a + b;
                    true_val = longint'($signed(a)) + longint'($signed(b));
                    ovf = (true_val != longint'($signed(res)));
                end
                6'h22: begin
                    fc = 1; res = a - b;
                    true_val = longint'($signed(a)) - longint'($signed(b));
                    ovf = (true_val != longint'($signed(res)));
                end
                6'h24: begin fc = 2;  res = a & b; end
                6'h25: begin fc = 3;  res = a | b; end
                6'h27: begin fc = 4;  res = ~(a | b); end
                6'h2a: begin fc = 5;  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
                6'h2b: begin fc = 8;  res = (a < b) ? 32'd1 : 32'd0; end
                6'h26: begin fc = 9;  res = a ^ b; end
                6'h00: begin fc = 10; res = b << sh; end
                6'h02: begin fc = 11; res = b >> sh; end
                6'h03: begin
                    fc = 12;
                    res = (b >> sh) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
                end
                6'h18: begin
                    fc = 13;
                    prod = {32'd0, a} * {32'd0, b};
                    res = prod[31:0];
                end
                default: ;
            endcase
        end else begin
            case (aop)
                4'd1: begin fc = 1; res = a - b; end
                4'd2: begin fc = 0; res = a + b; end
                4'd3: begin fc = 6; res = b; end
                4'd4: begin fc = 7; res = a + b; end
                4'd5: begin fc = 5; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
                4'd6: begin fc = 8; res = (a < b) ? 32'd1 : 32'd0; end
                4'd7: begin fc = 2; res = a & b; end
                4'd8: begin fc = 3; res = a | b; end
                4'd9: begin fc = 9; res = a ^ b; end
                default: ;
            endcase
        end
    endfunction

    // Issue one request from IDLE, wait for its result, check it, hold it
    // for 'hold' cycles with stray in_valid pulses, then release it.
    task automatic run_op(input string tag, input logic [3:0] aop, input logic [5:0] fn,
                          input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                          input int hold);
        logic [31:0] er;
        logic [3:0]  efc;
        logic        eovf;
        logic [31:0] held;
        logic        busy_ok;
        int          n;
        model(aop, fn, sh, a, b, er, efc, eovf);
        chk({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        alu_op   = aop;
        funct    = fn;
        shamt    = sh;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        busy_ok = 1'b1;
        while (!out_valid && n < 80) begin
            if (in_ready) busy_ok = 1'b0;
            in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        chk({tag, ".latency"}, 32'(n), (efc == 4'd13) ? 32'd33 : 32'd1);
        chk({tag, ".busy"}, 32'(busy_ok), 32'd1);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".result"}, result, er);
        chk({tag, ".func_code"}, 32'(func_code), 32'(efc));
        chk({tag, ".zero"}, 32'(zero), (er == 32'd0) ? 32'd1 : 32'd0);
        chk({tag, ".overflow"}, 32'(overflow), 32'(eovf));
        chk({tag, ".illegal"}, 32'(illegal), (efc == 4'd15) ? 32'd1 : 32'd0);
        held = result;
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            alu_op   = 4'($urandom);
            op_a     = $urandom;
            @(negedge clk);
            chk({tag, ".hold_result"}, result, held);
            chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
        end
        // in_valid stays high on the release edge: it must not be taken
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({tag, ".released"}, 32'(out_valid), 32'd0);
        chk({tag, ".ready_again"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] fn_tbl [13];
        logic [3:0] aop;
        logic [5:0] fn;
        logic [31:0] a, b;

        fn_tbl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h2b,
                   6'h26, 6'h00, 6'h02, 6'h03, 6'h18, 6'h08};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_op    = '0;
        funct     = '0;
        shamt     = '0;
        op_a      = '0;
        op_b      = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.result", result, 32'd0);
        chk("rst.func_code", 32'(func_code), 32'd0);
        chk("rst.flags", {29'd0, zero, overflow, illegal}, 32'd0);

        run_op("add_ovf",   4'b0000, 6'h20, 5'd0, 32'h7FFF_FFFF, 32'h1, 0);
        run_op("addiu",     4'b0100, 6'h20, 5'd0, 32'h7FFF_FFFF, 32'h1, 1);
        run_op("aluop_add", 4'b0010, 6'h00, 5'd0, 32'h7FFF_FFFF, 32'h1, 0);
        run_op("sub_ovf",   4'b0000, 6'h22, 5'd0, 32'h8000_0000, 32'h1, 0);
        run_op("slt",       4'b0000, 6'h2a, 5'd0, 32'hFFFF_FFFF, 32'h1, 0);
        run_op("sltu",      4'b0000, 6'h2b, 5'd0, 32'hFFFF_FFFF, 32'h1, 0);
        run_op("sltiu",     4'b0110, 6'h00, 5'd0, 32'hFFFF_FFFF, 32'h1, 0);
        run_op("sll",       4'b0000, 6'h00, 5'd4, 32'h0, 32'h8000_0010, 0);
        run_op("srl",       4'b0000, 6'h02, 5'd4, 32'h0, 32'h8000_0010, 0);
        run_op("sra",       4'b0000, 6'h03, 5'd4, 32'h0, 32'h8000_0010, 0);
        run_op("mult",      4'b0000, 6'h18, 5'd0, 32'h0001_2345, 32'h0001_0000, 5);
        run_op("ill_funct", 4'b0000, 6'h08, 5'd0, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        run_op("ill_aluop", 4'b1100, 6'h20, 5'd0, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        run_op("lui",       4'b0011, 6'h00, 5'd0, 32'h1111_1111, 32'hABCD_0000, 0);

        // Reset in the middle of a multiply discards it
        run_op("pre_rst",   4'b0000, 6'h25, 5'd0, 32'h00F0_0000, 32'h0000_000F, 0);
        alu_op   = 4'b0000;
        funct    = 6'h18;
        op_a     = 32'hDEAD_BEEF;
        op_b     = 32'h0000_0003;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("midmul.busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midmul_rst.out_valid", 32'(out_valid), 32'd0);
        chk("midmul_rst.result", result, 32'd0);
        chk("midmul_rst.in_ready", 32'(in_ready), 32'd1);
        repeat (40) @(negedge clk);
        chk("midmul_rst.no_late_valid", 32'(out_valid), 32'd0);

        for (int i = 0; i < 40; i++) begin
            aop = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            fn  = fn_tbl[$urandom_range(0, 12)];
            if ($urandom_range(0, 7) == 0) fn = 6'($urandom);
            case ($urandom_range(0, 3))
                0:       a = 32'h8000_0000;
                1:       a = 32'h7FFF_FFFF;
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            run_op("rand", aop, fn, 5'($urandom), a, b, int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
